// File: rtl/pio_out_blink.sv
// pio_out_blink: Avalon-MM output PIO driving WIDTH bits, with atomic set/clear
// writes, a per-bit blink mask and a programmable blink half-period counter.
// Lets LEDs flash without any CPU involvement after the initial setup.
module pio_out_blink #(
    parameter int unsigned                WIDTH        = 18,
    parameter int unsigned                PERIOD_W     = 24,
    parameter logic [WIDTH-1:0]           RESET_VALUE  = '0,
    parameter logic [PERIOD_W-1:0]        RESET_PERIOD = PERIOD_W'(2499999)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    // Register word addresses
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic [WIDTH-1:0]    data_q,   data_d;
    logic [WIDTH-1:0]    mask_q,   mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q,    cnt_d;
    logic                phase_q,  phase_d;

    logic                wr;
    logic                period_wr;
    logic [WIDTH-1:0]    wd_data;
    logic [PERIOD_W-1:0] wd_period;
    logic                writedata_unused;

    assign wr        = chipselect & ~write_n;
    assign period_wr = wr && (address == ADDR_PERIOD);
    assign wd_data   = writedata[WIDTH-1:0];
    assign wd_period = writedata[PERIOD_W-1:0];

    // Upper writedata bits beyond WIDTH/PERIOD_W are ignored by design.
    assign writedata_unused = ^writedata;

    // Next-state for the software-visible registers (DATA, MASK, PERIOD)
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_d   = wd_data;
                ADDR_MASK:     mask_d   = wd_data;
                ADDR_PERIOD:   period_d = wd_period;
                ADDR_OUTSET:   data_d   = data_q | wd_data;
                ADDR_OUTCLEAR: data_d   = data_q & ~wd_data;
                default:       ;
            endcase
        end
    end

    // Next-state for the blink half-period counter and phase
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period_wr) begin
            // Restart cleanly so a new, smaller period can never be overshot.
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (mask_q == '0) begin
            // Idle while nothing blinks; the first nonzero MASK starts from zero.
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            data_q   <= RESET_VALUE;
            mask_q   <= '0;
            period_q <= RESET_PERIOD;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    // Zero-wait-state read mux, zero-extended to 32 bits, no side effects
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA,
            ADDR_OUTSET,
            ADDR_OUTCLEAR: readdata = 32'(data_q);
            ADDR_MASK:     readdata = 32'(mask_q);
            ADDR_PERIOD:   readdata = 32'(period_q);
            ADDR_STATUS:   readdata = {31'b0, phase_q};
            default:       readdata = '0;
        endcase
    end

    // Masked bits follow DATA only while phase is high; others follow DATA
    assign out_port = data_q & (~mask_q | {WIDTH{phase_q}});

endmodule

// File: tb/tb_pio_out_blink.sv
// Directed testbench for pio_out_blink with default parameters
// (WIDTH=18, PERIOD_W=24, RESET_VALUE=0, RESET_PERIOD=2499999).
`timescale 1ns/1ps
module tb_pio_out_blink;

    localparam int unsigned WIDTH = 18;

    logic             clk;
    logic             reset_n;
    logic             chipselect;
    logic [2:0]       address;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int checks = 0;
    int errors = 0;

    pio_out_blink dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    // 20 ns clock: posedges at 10, 30, 50 ...; negedges at 20, 40 ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp_rd;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Single-cycle write: drive at negedge, captured at next posedge, return 1 ns after it
    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = addr;
        writedata  = data;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_check(input string name, input logic [2:0] addr, input logic [31:0] exp);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(name, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_phase;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;

        //          we    waddr  wdata          raddr  exp_rd         exp_out
        vecs[0]  = '{1'b0, 3'd0, 32'h0000_0000, 3'd0, 32'h0000_0000, 32'h00000}; // reset state
        vecs[1]  = '{1'b1, 3'd0, 32'hFFFF_FFFF, 3'd0, 32'h0003_FFFF, 32'h3FFFF}; // upper bits dropped
        vecs[2]  = '{1'b0, 3'd0, 32'h0000_0000, 3'd6, 32'h0000_0000, 32'h3FFFF}; // addr6 reads 0
        vecs[3]  = '{1'b1, 3'd0, 32'h0000_00F0, 3'd0, 32'h0000_00F0, 32'h000F0};
        vecs[4]  = '{1'b1, 3'd4, 32'h0000_0003, 3'd0, 32'h0000_00F3, 32'h000F3}; // OUTSET
        vecs[5]  = '{1'b1, 3'd5, 32'h0000_0030, 3'd4, 32'h0000_00C3, 32'h000C3}; // OUTCLEAR
        vecs[6]  = '{1'b0, 3'd0, 32'h0000_0000, 3'd5, 32'h0000_00C3, 32'h000C3};
        vecs[7]  = '{1'b1, 3'd6, 32'h0000_FFFF, 3'd0, 32'h0000_00C3, 32'h000C3}; // addr6 write ignored
        vecs[8]  = '{1'b1, 3'd3, 32'h0000_FFFF, 3'd3, 32'h0000_0000, 32'h000C3}; // STATUS write ignored
        vecs[9]  = '{1'b1, 3'd2, 32'h0000_0003, 3'd2, 32'h0000_0003, 32'h000C3}; // PERIOD=3
        vecs[10] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 3'd7, 32'h0000_0000, 32'h000C3}; // addr7 ignored

        #35;
        reset_n = 1'b1;

        // Register map and DATA path
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].we) bus_write(vecs[i].waddr, vecs[i].wdata);
            else            step();
            check($sformatf("vec%0d_out", i), 32'(out_port), vecs[i].exp_out);
            read_check($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
        end

        // Blink timing: PERIOD=3, DATA=5, MASK=1; phase flips every 4 edges
        bus_write(3'd0, 32'h5);
        bus_write(3'd1, 32'h1);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            exp_phase = ((k / 4) % 2) == 1;
            check($sformatf("blink_out_k%0d", k), 32'(out_port), exp_phase ? 32'h5 : 32'h4);
            read_check($sformatf("blink_status_k%0d", k), 3'd3, {31'b0, exp_phase});
        end

        // PERIOD=0: phase toggles every edge
        bus_write(3'd2, 32'h0);
        read_check("p0_status_k0", 3'd3, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            read_check($sformatf("p0_status_k%0d", k), 3'd3, 32'(k % 2));
        end
        // MASK=0: output follows DATA at once; phase idles to 0 on the next edge
        bus_write(3'd1, 32'h0);
        check("mask0_out_now", 32'(out_port), 32'h5);
        step();
        read_check("mask0_status_next", 3'd3, 32'h0);
        check("mask0_out_next", 32'(out_port), 32'h5);

        // PERIOD rewrite mid-count: PERIOD=10, reach cnt=7, then PERIOD=2
        bus_write(3'd2, 32'd10);
        bus_write(3'd1, 32'h1);          // cnt=0 after this edge
        for (int k = 0; k < 7; k++) step(); // cnt=7, phase still 0
        read_check("rew_status_cnt7", 3'd3, 32'h0);
        bus_write(3'd2, 32'd2);          // cnt=0, phase=0
        read_check("rew_status_e0", 3'd3, 32'h0);
        step();
        read_check("rew_status_e1", 3'd3, 32'h0);
        step();
        read_check("rew_status_e2", 3'd3, 32'h0);
        step();
        read_check("rew_status_e3", 3'd3, 32'h1);
        check("rew_out_phase1", 32'(out_port), 32'h5);

        // Asynchronous reset between clock edges while phase=1
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("areset_out", 32'(out_port), 32'h0);
        read_check("areset_status", 3'd3, 32'h0);
        read_check("areset_mask", 3'd1, 32'h0);
        read_check("areset_data", 3'd0, 32'h0);
        #2;
        reset_n = 1'b1;
        read_check("areset_period", 3'd2, 32'd2499999);
        step();
        read_check("post_reset_period", 3'd2, 32'd2499999);
        check("post_reset_out", 32'(out_port), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
